// File: rtl/tinynpu_loader_if.sv
// Host/NPU-facing bundle of the tinynpu loader.
// The slave modport is the loader's view; the master modport is the host/NPU environment.
interface tinynpu_loader_if #(
    parameter int SIZE  = 4,
    parameter int NBITS = 8
);
    logic                    start;
    logic                    in_val;
    logic [NBITS-1:0]        in_data;
    logic                    in_rdy;
    logic [NBITS-1:0]        x_in;
    logic                    x_load_val;
    logic [NBITS-1:0]        w_in;
    logic                    w_load_val;
    logic [$clog2(SIZE)-1:0] w_load_sel;
    logic                    mac_val;
    logic                    out_val;
    logic [NBITS-1:0]        z_out;
    logic                    res_val;
    logic [NBITS-1:0]        res_data;
    logic                    res_rdy;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start, in_val, in_data, z_out, res_rdy,
        output in_rdy, x_in, x_load_val, w_in, w_load_val, w_load_sel,
               mac_val, out_val, res_val, res_data, busy, done
    );

    modport master (
        output start, in_val, in_data, z_out, res_rdy,
        input  in_rdy, x_in, x_load_val, w_in, w_load_val, w_load_sel,
               mac_val, out_val, res_val, res_data, busy, done
    );
endinterface

// File: rtl/tinynpu_loader.sv
// Job sequencer: streams SIZE*SIZE weights then SIZE activations into the NPU, fires a MAC, reads back SIZE results.
// Loads appear one cycle after each in_val/in_rdy transfer; results are held under res_rdy backpressure.
module tinynpu_loader #(
    parameter int SIZE    = 4,
    parameter int NBITS   = 8,
    parameter int MAC_LAT = 4,
    parameter int OUT_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    tinynpu_loader_if.slave bus
);
    localparam int SW      = $clog2(SIZE);
    localparam int C_W     = SIZE * SIZE - 1;
    localparam int C_R     = OUT_LAT + SIZE - 1;
    localparam int CNT_MAX = (C_W > MAC_LAT) ? ((C_W > C_R) ? C_W : C_R)
                                             : ((MAC_LAT > C_R) ? MAC_LAT : C_R);
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, WAIT, READ, RESULT} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_ridx;
    logic [NBITS-1:0] r_buf [SIZE];
    logic             r_in_rdy;
    logic [NBITS-1:0] r_x_in;
    logic             r_x_load_val;
    logic [NBITS-1:0] r_w_in;
    logic             r_w_load_val;
    logic [SW-1:0]    r_w_load_sel;
    logic             r_mac_val;
    logic             r_out_val;
    logic             r_res_val;
    logic [NBITS-1:0] r_res_data;
    logic             r_busy;
    logic             r_done;

    logic             w_xfer;
    logic [SW-1:0]    w_row;
    logic [SW-1:0]    w_widx;
    logic [SW-1:0]    w_ridx_nxt;

    assign w_xfer     = bus.in_val && r_in_rdy;
    assign w_row      = SW'(r_cnt / CW'(SIZE));
    assign w_widx     = SW'(r_cnt - CW'(OUT_LAT));
    assign w_ridx_nxt = r_ridx + SW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ridx       <= '0;
            for (int i = 0; i < SIZE; i++) r_buf[i] <= '0;
            r_in_rdy     <= 1'b0;
            r_x_in       <= '0;
            r_x_load_val <= 1'b0;
            r_w_in       <= '0;
            r_w_load_val <= 1'b0;
            r_w_load_sel <= '0;
            r_mac_val    <= 1'b0;
            r_out_val    <= 1'b0;
            r_res_val    <= 1'b0;
            r_res_data   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_w_load_val <= 1'b0;
            r_x_load_val <= 1'b0;
            r_mac_val    <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                // A start coinciding with the done pulse is dropped.
                IDLE: if (bus.start && !r_done) begin
                    r_state  <= LOAD_W;
                    r_cnt    <= '0;
                    r_ridx   <= '0;
                    r_in_rdy <= 1'b1;
                    r_busy   <= 1'b1;
                end
                LOAD_W: if (w_xfer) begin
                    r_w_in       <= bus.in_data;
                    r_w_load_sel <= w_row;
                    r_w_load_val <= 1'b1;
                    if (r_cnt == CW'(C_W)) begin
                        r_cnt   <= '0;
                        r_state <= LOAD_X;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                LOAD_X: if (w_xfer) begin
                    r_x_in       <= bus.in_data;
                    r_x_load_val <= 1'b1;
                    if (r_cnt == CW'(SIZE - 1)) begin
                        r_cnt    <= '0;
                        r_in_rdy <= 1'b0;
                        r_state  <= COMPUTE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                COMPUTE: begin
                    r_mac_val <= 1'b1;
                    r_state   <= WAIT;
                end
                // mac_val is visible in the first WAIT cycle, so WAIT spans MAC_LAT+1 cycles
                // to leave MAC_LAT quiet cycles before out_val rises.
                WAIT: if (r_cnt == CW'(MAC_LAT)) begin
                    r_cnt     <= '0;
                    r_out_val <= 1'b1;
                    r_state   <= READ;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                // r_cnt counts cycles with out_val high; index OUT_LAT+j carries result j.
                READ: begin
                    if (r_cnt >= CW'(OUT_LAT)) r_buf[w_widx] <= bus.z_out;
                    if (r_cnt == CW'(C_R)) begin
                        r_cnt      <= '0;
                        r_out_val  <= 1'b0;
                        r_res_val  <= 1'b1;
                        r_res_data <= r_buf[0];
                        r_ridx     <= '0;
                        r_state    <= RESULT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RESULT: if (bus.res_rdy) begin
                    if (r_ridx == SW'(SIZE - 1)) begin
                        r_res_val <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_ridx     <= w_ridx_nxt;
                        r_res_data <= r_buf[w_ridx_nxt];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy     = r_in_rdy;
    assign bus.x_in       = r_x_in;
    assign bus.x_load_val = r_x_load_val;
    assign bus.w_in       = r_w_in;
    assign bus.w_load_val = r_w_load_val;
    assign bus.w_load_sel = r_w_load_sel;
    assign bus.mac_val    = r_mac_val;
    assign bus.out_val    = r_out_val;
    assign bus.res_val    = r_res_val;
    assign bus.res_data   = r_res_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: doc/tinynpu_loader.md
TINYNPU_LOADER -- requirements
Module: tinynpu_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- SIZE, 4, PE count and vector length
- NBITS, 8, word width
- MAC_LAT, 4, idle cycles after mac_val before readout
- OUT_LAT, 2, cycles from out_val rise to first valid z_out
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin one job; ignored unless busy=0
- in_val  input  1  host word valid
- in_data  input  NBITS  host word (weights, then activations)
- in_rdy  output  1  loader accepts in_data
- x_in  output  NBITS  activation word to NPU
- x_load_val  output  1  x_in valid
- w_in  output  NBITS  weight word to NPU
- w_load_val  output  1  w_in valid
- w_load_sel  output  $clog2(SIZE)  target weight FIFO
- mac_val  output  1  compute request pulse to NPU
- out_val  output  1  readout request to NPU
- z_out  input  NBITS  NPU result word
- res_val  output  1  result word valid
- res_data  output  NBITS  result word
- res_rdy  input  1  host accepts result
- busy  output  1  job in progress
- done  output  1  one-cycle pulse, job complete

Function
REQ-003 FSM states SHALL be IDLE, LOAD_W, LOAD_X, COMPUTE, WAIT, READ, RESULT; busy=1 in every state except IDLE.
REQ-004 IDLE->LOAD_W on start=1; all counters cleared on this transition.
REQ-005 in_rdy SHALL be 1 only in LOAD_W and LOAD_X; a transfer occurs when in_val&&in_rdy.
REQ-006 LOAD_W: SIZE*SIZE transfers; transfer k (0-based) SHALL appear one cycle later as w_in=in_data, w_load_sel=k/SIZE, w_load_val=1 for exactly one cycle.
REQ-007 After transfer SIZE*SIZE-1, next state SHALL be LOAD_X; in_rdy SHALL remain 1 so back-to-back transfers incur no bubble.
REQ-008 LOAD_X: SIZE transfers; each SHALL appear one cycle later as x_in=in_data, x_load_val=1 for one cycle; after the last, next state COMPUTE.
REQ-009 in_val=0 cycles SHALL stall the counters; load_val outputs SHALL be 0 in the cycle after a non-transfer.
REQ-010 COMPUTE: mac_val=1 for exactly one cycle, then WAIT.
REQ-011 WAIT: MAC_LAT cycles with all NPU outputs low, then READ.
REQ-012 READ: out_val=1 for OUT_LAT+SIZE cycles; z_out SHALL be captured into result buffer entry j in READ cycle OUT_LAT+j, j=0..SIZE-1; then RESULT.
REQ-013 RESULT: res_val=1 and res_data=buffer[r] for r=0..SIZE-1; r advances only on res_val&&res_rdy; res_val held with stable res_data while res_rdy=0.
REQ-014 On the final result handshake, done SHALL pulse 1 in the next cycle and FSM SHALL return to IDLE in that cycle.
REQ-015 start while busy=1 SHALL be ignored with no side effects; start in the same cycle done=1 SHALL not be accepted.
REQ-016 x_in, w_in, w_load_sel SHALL hold their last value when their load_val is 0.

Reset
REQ-017 rst=0 SHALL asynchronously force state IDLE, all counters 0, result buffer 0, and every output 0 (x_in, w_in, w_load_sel, res_data included), regardless of in-progress job.
REQ-018 After rst deasserts, the block SHALL take no action until a new start; a reset mid-job SHALL not cause a done pulse.

Verification (SIZE=4, MAC_LAT=4, OUT_LAT=2)
REQ-019 Streaming load: start, 16 weights 0x10..0x1F then 4 activations 0x01..0x04, in_val constant 1 -> w_load_sel 0,0,0,0,1,...,3 with w_in 0x10..0x1F on 16 consecutive cycles, then x_in 0x01..0x04 on 4 cycles, one-cycle mac_val, 4 quiet cycles, out_val high 6 cycles.
REQ-020 Readout: z_out=0xA0,0xA1,0xA2,0xA3 in READ cycles 2..5, res_rdy=1 -> res_data 0xA0..0xA3 on 4 consecutive cycles, done pulse next cycle, busy=0.
REQ-021 Backpressure: in_val toggling 1/0 during LOAD_W and res_rdy=0 for 3 cycles at r=1 -> same output sequences with gaps; res_data=0xA1 held stable while stalled.
REQ-022 Ignored start: start pulsed during LOAD_X and WAIT -> no counter reset, identical transaction outputs.
REQ-023 Mid-job reset: rst=0 during READ -> all outputs 0 immediately; no done; a fresh full job afterwards completes correctly.
